// File: rtl/spi_cmd_sequencer.sv
// rtl/spi_cmd_sequencer.sv - command FIFO and one-at-a-time transaction sequencer for the board SPI master
module spi_cmd_sequencer #(
  parameter int CMD_DEPTH      = 4,
  parameter int START_CYCLES   = 4,
  parameter int GAP_CYCLES     = 8,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic        BOARD_CLOCK,
  input  logic        RST,
  input  logic        CMD_VALID_I,
  output logic        CMD_READY_O,
  input  logic [1:0]  CMD_SEL_I,
  input  logic [31:0] CMD_DATA_I,
  output logic        RSP_VALID_O,
  input  logic        RSP_READY_I,
  output logic [31:0] RSP_DATA_O,
  output logic [1:0]  RSP_SEL_O,
  output logic        RSP_ERR_O,
  output logic        RSP_TIMEOUT_O,
  output logic [31:0] SPI_TX_O,
  output logic [1:0]  SPI_SEL_O,
  output logic        SPI_STAR_O,
  input  logic [31:0] SPI_RX_I,
  input  logic        SPI_DONE_I,
  output logic        BUSY_O
);

  localparam int AW = $clog2(CMD_DEPTH);
  localparam logic [AW:0] CNT_FULL   = (AW+1)'(CMD_DEPTH);
  localparam logic [3:0]  START_LAST = 4'(START_CYCLES - 1);
  localparam logic [15:0] TMO_LAST   = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]  GAP_LAST   = (GAP_CYCLES == 0) ? 8'd0 : 8'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, START, WAIT, CAPTURE, GAP} state_t;

  state_t        state_q, state_d;
  logic [1:0]    rst_sync_q;
  logic          rst_int_n;
  logic [33:0]   mem [CMD_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          push, pop, arm_q, arm_d, done_q, done_evt;
  logic [1:0]    head_sel;
  logic [31:0]   head_data;
  logic [3:0]    start_cnt;
  logic [15:0]   tmo_cnt;
  logic [7:0]    gap_cnt;
  logic          tx_load, star_d, rsp_load, rsp_err_d, rsp_tmo_d;
  logic [31:0]   rsp_data_d;
  logic [1:0]    rsp_sel_d;

  // Reset asserts asynchronously but is released on a clock edge
  always_ff @(posedge BOARD_CLOCK or negedge RST) begin
    if (!RST) rst_sync_q <= 2'b00;
    else      rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_int_n = rst_sync_q[1];

  assign CMD_READY_O = (count != CNT_FULL);
  assign push        = CMD_VALID_I & CMD_READY_O;
  assign head_sel    = mem[rd_ptr][33:32];
  assign head_data   = mem[rd_ptr][31:0];
  assign done_evt    = SPI_DONE_I & ~done_q;
  assign BUSY_O      = (state_q != IDLE) || (count != '0);

  always_ff @(posedge BOARD_CLOCK) begin
    if (push) mem[wr_ptr] <= {CMD_SEL_I, CMD_DATA_I};
  end

  always_ff @(posedge BOARD_CLOCK or negedge rst_int_n) begin
    if (!rst_int_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= SPI_DONE_I;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge BOARD_CLOCK or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_q <= IDLE;
      arm_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      arm_q   <= arm_d;
    end
  end

  // IDLE spends one cycle arming on a non-empty FIFO, then pops and launches
  always_comb begin
    state_d    = state_q;
    arm_d      = 1'b0;
    pop        = 1'b0;
    tx_load    = 1'b0;
    star_d     = SPI_STAR_O;
    rsp_load   = 1'b0;
    rsp_data_d = '0;
    rsp_sel_d  = SPI_SEL_O;
    rsp_err_d  = 1'b0;
    rsp_tmo_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (arm_q) begin
          pop = 1'b1;
          if (head_sel == 2'd3) begin
            rsp_load  = 1'b1;
            rsp_sel_d = head_sel;
            rsp_err_d = 1'b1;
            state_d   = GAP;
          end else begin
            tx_load = 1'b1;
            star_d  = 1'b1;
            state_d = START;
          end
        end else begin
          arm_d = (count != '0) && !RSP_VALID_O;
        end
      end
      START: begin
        if (done_evt) begin
          star_d  = 1'b0;
          state_d = CAPTURE;
        end else if (start_cnt == START_LAST) begin
          star_d  = 1'b0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (done_evt) begin
          state_d = CAPTURE;
        end else if (tmo_cnt == TMO_LAST) begin
          rsp_load   = 1'b1;
          rsp_data_d = 32'hFFFF_FFFF;
          rsp_tmo_d  = 1'b1;
          state_d    = GAP;
        end
      end
      CAPTURE: begin
        rsp_load   = 1'b1;
        rsp_data_d = SPI_RX_I;
        state_d    = GAP;
      end
      GAP: begin
        if (gap_cnt == GAP_LAST) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge BOARD_CLOCK or negedge rst_int_n) begin
    if (!rst_int_n) begin
      SPI_TX_O      <= '0;
      SPI_SEL_O     <= '0;
      SPI_STAR_O    <= 1'b0;
      start_cnt     <= '0;
      tmo_cnt       <= '0;
      gap_cnt       <= '0;
      RSP_VALID_O   <= 1'b0;
      RSP_DATA_O    <= '0;
      RSP_SEL_O     <= '0;
      RSP_ERR_O     <= 1'b0;
      RSP_TIMEOUT_O <= 1'b0;
    end else begin
      SPI_STAR_O <= star_d;
      if (tx_load) begin
        SPI_TX_O  <= head_data;
        SPI_SEL_O <= head_sel;
        start_cnt <= '0;
        tmo_cnt   <= '0;
      end else begin
        if (state_q == START) start_cnt <= start_cnt + 1'b1;
        if (state_q == START || state_q == WAIT) tmo_cnt <= tmo_cnt + 1'b1;
      end
      gap_cnt <= (state_q == GAP) ? gap_cnt + 1'b1 : 8'd0;
      if (rsp_load) begin
        RSP_VALID_O   <= 1'b1;
        RSP_DATA_O    <= rsp_data_d;
        RSP_SEL_O     <= rsp_sel_d;
        RSP_ERR_O     <= rsp_err_d;
        RSP_TIMEOUT_O <= rsp_tmo_d;
      end else if (RSP_VALID_O && RSP_READY_I) begin
        RSP_VALID_O <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spi_cmd_sequencer.sv
// tb/tb_spi_cmd_sequencer.sv - directed self-checking bench for spi_cmd_sequencer
module tb_spi_cmd_sequencer;

  logic        BOARD_CLOCK = 1'b0;
  logic        RST = 1'b0;
  logic        CMD_VALID_I = 1'b0;
  logic        CMD_READY_O;
  logic [1:0]  CMD_SEL_I = '0;
  logic [31:0] CMD_DATA_I = '0;
  logic        RSP_VALID_O;
  logic        RSP_READY_I = 1'b0;
  logic [31:0] RSP_DATA_O;
  logic [1:0]  RSP_SEL_O;
  logic        RSP_ERR_O;
  logic        RSP_TIMEOUT_O;
  logic [31:0] SPI_TX_O;
  logic [1:0]  SPI_SEL_O;
  logic        SPI_STAR_O;
  logic [31:0] SPI_RX_I = '0;
  logic        SPI_DONE_I = 1'b0;
  logic        BUSY_O;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0;
  int star_rises = 0;
  int last_fall = 0;
  int t_mark, rises0;
  logic star_q = 1'b0;

  spi_cmd_sequencer dut (
    .BOARD_CLOCK(BOARD_CLOCK), .RST(RST),
    .CMD_VALID_I(CMD_VALID_I), .CMD_READY_O(CMD_READY_O),
    .CMD_SEL_I(CMD_SEL_I), .CMD_DATA_I(CMD_DATA_I),
    .RSP_VALID_O(RSP_VALID_O), .RSP_READY_I(RSP_READY_I),
    .RSP_DATA_O(RSP_DATA_O), .RSP_SEL_O(RSP_SEL_O),
    .RSP_ERR_O(RSP_ERR_O), .RSP_TIMEOUT_O(RSP_TIMEOUT_O),
    .SPI_TX_O(SPI_TX_O), .SPI_SEL_O(SPI_SEL_O), .SPI_STAR_O(SPI_STAR_O),
    .SPI_RX_I(SPI_RX_I), .SPI_DONE_I(SPI_DONE_I), .BUSY_O(BUSY_O)
  );

  always #5 BOARD_CLOCK = ~BOARD_CLOCK;

  always @(posedge BOARD_CLOCK) begin
    cyc    <= cyc + 1;
    star_q <= SPI_STAR_O;
    if (SPI_STAR_O && !star_q) star_rises <= star_rises + 1;
  end

  task automatic tick();
    @(posedge BOARD_CLOCK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [1:0] sel, input logic [31:0] data);
    CMD_VALID_I = 1'b1;
    CMD_SEL_I   = sel;
    CMD_DATA_I  = data;
    tick();
    CMD_VALID_I = 1'b0;
  endtask

  task automatic wait_star(input string tag);
    int n = 0;
    while (SPI_STAR_O !== 1'b1 && n < 200) begin tick(); n++; end
    chk(tag, 32'(SPI_STAR_O), 32'd1);
  endtask

  task automatic do_done(input logic [31:0] rx);
    int n = 0;
    while (SPI_STAR_O === 1'b1 && n < 50) begin tick(); n++; end
    chk("star_fall", 32'(SPI_STAR_O), 32'd0);
    last_fall  = cyc;
    SPI_RX_I   = rx;
    SPI_DONE_I = 1'b1;
    tick();
    SPI_DONE_I = 1'b0;
  endtask

  task automatic wait_rsp(input string tag, input int budget);
    int n = 0;
    while (RSP_VALID_O !== 1'b1 && n < budget) begin tick(); n++; end
    chk(tag, 32'(RSP_VALID_O), 32'd1);
  endtask

  initial begin
    // Reset state
    repeat (3) tick();
    chk("rst_ready", 32'(CMD_READY_O), 32'd1);
    chk("rst_rsp_valid", 32'(RSP_VALID_O), 32'd0);
    chk("rst_star", 32'(SPI_STAR_O), 32'd0);
    chk("rst_busy", 32'(BUSY_O), 32'd0);
    chk("rst_tx", SPI_TX_O, 32'd0);
    RST = 1'b1;
    repeat (3) tick();
    chk("post_rst_busy", 32'(BUSY_O), 32'd0);

    // Single write: latency, START width, master done 40 cycles after start
    push(2'd2, 32'hCCCC_CCCE);
    chk("lat_n", 32'(SPI_STAR_O), 32'd0);
    chk("busy_queued", 32'(BUSY_O), 32'd1);
    tick();
    chk("lat_n1", 32'(SPI_STAR_O), 32'd0);
    tick();
    chk("lat_n2_star", 32'(SPI_STAR_O), 32'd1);
    chk("w1_tx", SPI_TX_O, 32'hCCCC_CCCE);
    chk("w1_sel", 32'(SPI_SEL_O), 32'd2);
    for (int i = 1; i < 4; i++) begin
      tick();
      chk($sformatf("w1_star_hi_%0d", i), 32'(SPI_STAR_O), 32'd1);
    end
    tick();
    chk("w1_star_lo", 32'(SPI_STAR_O), 32'd0);
    repeat (36) tick();
    SPI_RX_I   = 32'hFFFF_FFFF;
    SPI_DONE_I = 1'b1;
    tick();
    SPI_DONE_I = 1'b0;
    chk("w1_rsp_not_yet", 32'(RSP_VALID_O), 32'd0);
    tick();
    chk("w1_rsp_valid", 32'(RSP_VALID_O), 32'd1);
    chk("w1_rsp_data", RSP_DATA_O, 32'hFFFF_FFFF);
    chk("w1_rsp_sel", 32'(RSP_SEL_O), 32'd2);
    chk("w1_rsp_err", 32'(RSP_ERR_O), 32'd0);
    chk("w1_rsp_tmo", 32'(RSP_TIMEOUT_O), 32'd0);
    chk("w1_tx_stable", SPI_TX_O, 32'hCCCC_CCCE);
    RSP_READY_I = 1'b1;
    tick();
    RSP_READY_I = 1'b0;
    chk("w1_rsp_taken", 32'(RSP_VALID_O), 32'd0);
    repeat (15) tick();
    chk("w1_idle", 32'(BUSY_O), 32'd0);

    // Queue fill behind an unconsumed response
    rises0 = star_rises;
    push(2'd0, 32'hA0A0_A0A0);
    wait_star("blk_star");
    do_done(32'h0A0A_0A0A);
    wait_rsp("blk_rsp", 20);
    for (int k = 0; k < 5; k++) begin
      CMD_VALID_I = 1'b1;
      CMD_SEL_I   = 2'd1;
      CMD_DATA_I  = 32'hB000_0000 + 32'(k);
      chk($sformatf("fill_ready_%0d", k), 32'(CMD_READY_O), (k < 4) ? 32'd1 : 32'd0);
      tick();
    end
    CMD_VALID_I = 1'b0;
    repeat (20) tick();
    chk("fill_one_txn", 32'(star_rises - rises0), 32'd1);
    chk("fill_rsp_held", RSP_DATA_O, 32'h0A0A_0A0A);
    RSP_READY_I = 1'b1;
    tick();
    for (int k = 0; k < 4; k++) begin
      wait_star($sformatf("q%0d_star", k));
      chk($sformatf("q%0d_gap_ok", k), 32'(cyc - last_fall >= 8), 32'd1);
      chk($sformatf("q%0d_tx", k), SPI_TX_O, 32'hB000_0000 + 32'(k));
      do_done(32'h5000_0000 + 32'(k));
      wait_rsp($sformatf("q%0d_rsp", k), 20);
      chk($sformatf("q%0d_data", k), RSP_DATA_O, 32'h5000_0000 + 32'(k));
      chk($sformatf("q%0d_sel", k), 32'(RSP_SEL_O), 32'd1);
    end
    repeat (30) tick();
    chk("fill_fifth_dropped", 32'(star_rises - rises0), 32'd5);
    chk("fill_drained", 32'(BUSY_O), 32'd0);
    RSP_READY_I = 1'b0;

    // Invalid select
    rises0 = star_rises;
    push(2'd3, 32'h1234_5678);
    wait_rsp("inv_rsp", 20);
    chk("inv_err", 32'(RSP_ERR_O), 32'd1);
    chk("inv_data", RSP_DATA_O, 32'd0);
    chk("inv_sel", 32'(RSP_SEL_O), 32'd3);
    chk("inv_tmo", 32'(RSP_TIMEOUT_O), 32'd0);
    repeat (3) tick();
    chk("inv_no_star", 32'(star_rises - rises0), 32'd0);
    RSP_READY_I = 1'b1;
    repeat (15) tick();

    // Timeout with done held low, then a normal command
    push(2'd1, 32'h0BAD_0001);
    wait_star("tmo_star");
    t_mark = cyc;
    wait_rsp("tmo_rsp", 5000);
    chk("tmo_latency", 32'(cyc - t_mark), 32'd4096);
    chk("tmo_flag", 32'(RSP_TIMEOUT_O), 32'd1);
    chk("tmo_data", RSP_DATA_O, 32'hFFFF_FFFF);
    chk("tmo_err", 32'(RSP_ERR_O), 32'd0);
    chk("tmo_sel", 32'(RSP_SEL_O), 32'd1);
    push(2'd0, 32'h55AA_55AA);
    wait_star("after_tmo_star");
    chk("after_tmo_tx", SPI_TX_O, 32'h55AA_55AA);
    do_done(32'h1357_9BDF);
    wait_rsp("after_tmo_rsp", 20);
    chk("after_tmo_data", RSP_DATA_O, 32'h1357_9BDF);
    chk("after_tmo_flag", 32'(RSP_TIMEOUT_O), 32'd0);
    repeat (15) tick();

    // Level done: only the rising edge counts
    push(2'd2, 32'h0000_1111);
    wait_star("lvl1_star");
    while (SPI_STAR_O === 1'b1) tick();
    SPI_RX_I   = 32'h2222_2222;
    SPI_DONE_I = 1'b1;
    wait_rsp("lvl1_rsp", 20);
    chk("lvl1_data", RSP_DATA_O, 32'h2222_2222);
    chk("lvl1_tmo", 32'(RSP_TIMEOUT_O), 32'd0);
    repeat (15) tick();
    push(2'd2, 32'h0000_2222);
    wait_star("lvl2_star");
    wait_rsp("lvl2_rsp", 5000);
    chk("lvl2_tmo", 32'(RSP_TIMEOUT_O), 32'd1);
    chk("lvl2_data", RSP_DATA_O, 32'hFFFF_FFFF);
    SPI_DONE_I = 1'b0;
    repeat (15) tick();

    // Reset mid-WAIT with a second command queued
    push(2'd0, 32'hD100_0001);
    push(2'd1, 32'hD200_0002);
    wait_star("rw_star");
    while (SPI_STAR_O === 1'b1) tick();
    tick();
    chk("rw_tx_before", SPI_TX_O, 32'hD100_0001);
    RST = 1'b0;
    #1;
    chk("rw_tx_async", SPI_TX_O, 32'd0);
    chk("rw_busy_async", 32'(BUSY_O), 32'd0);
    chk("rw_ready_async", 32'(CMD_READY_O), 32'd1);
    chk("rw_star_async", 32'(SPI_STAR_O), 32'd0);
    repeat (3) tick();
    RST = 1'b1;
    rises0 = star_rises;
    repeat (20) tick();
    chk("rw_fifo_empty", 32'(BUSY_O), 32'd0);
    chk("rw_no_star", 32'(star_rises - rises0), 32'd0);
    chk("rw_no_rsp", 32'(RSP_VALID_O), 32'd0);
    push(2'd2, 32'h600D_0001);
    wait_star("rw_fresh_star");
    chk("rw_fresh_tx", SPI_TX_O, 32'h600D_0001);
    do_done(32'h7777_0001);
    wait_rsp("rw_fresh_rsp", 20);
    chk("rw_fresh_data", RSP_DATA_O, 32'h7777_0001);
    chk("rw_fresh_sel", 32'(RSP_SEL_O), 32'd2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
